router_apb_ctrl: RTL and testbench

Packet-steering controller for the 1-to-4 serial router, programmed over APB. Accepts a serial packet on `data_in`/`valid_in` and decodes a 2-bit destination header. Forwards the payload bits to one of four output ports. Per-port enables, per-port packet counters and a drop counter are exposed as APB registers so the RAL model can configure and check the router.

---
 rtl/router_pkg.sv | 16 +
 rtl/router_apb_if.sv | 14 +
 rtl/router_apb_regs.sv | 86 ++++++++
 rtl/router_apb_ctrl.sv | 96 +++++++++
 tb/tb_router_apb_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and register map for the APB-programmed serial router
package router_pkg;

  typedef enum logic [1:0] {IDLE, HDR, FWD, DROP} state_t;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_DROP   = 8'h08;
  localparam logic [7:0] ADDR_PKT1   = 8'h10;
  localparam logic [7:0] ADDR_PKT2   = 8'h14;
  localparam logic [7:0] ADDR_PKT3   = 8'h18;
  localparam logic [7:0] ADDR_PKT4   = 8'h1C;

  localparam logic [31:0] CTRL_RESET = 32'h0000_00F0;

endpackage

// File: rtl/router_apb_if.sv
// rtl/router_apb_if.sv - APB register bus bundle for the router controller
interface router_apb_if;

  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pwrite;
  logic        psel;
  logic        penable;

  modport master (output paddr, pwdata, pwrite, psel, penable, input prdata);
  modport slave  (input paddr, pwdata, pwrite, psel, penable, output prdata);

endinterface

// File: rtl/router_apb_regs.sv
// rtl/router_apb_regs.sv - APB decode, CTRL/STATUS storage and clear-on-write counters
module router_apb_regs
  import router_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  router_apb_if.slave      apb,
  input  logic             busy,
  input  logic             pkt_inc,
  input  logic             drop_inc,
  input  logic             status_upd,
  input  logic             status_dropped,
  input  logic [1:0]       dest,
  output logic             en,
  output logic [3:0]       port_en
);

  logic             wr;
  logic             rd;
  logic [7:0]       addr;
  logic [31:0]      rdata;
  logic [1:0]       last_dest;
  logic             last_dropped;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] pkt_cnt [4];
  logic             pkt_sel;

  assign addr    = apb.paddr[7:0];
  assign wr      = apb.psel & apb.penable & apb.pwrite;
  assign rd      = apb.psel & ~apb.penable & ~apb.pwrite;
  assign pkt_sel = (addr[7:4] == ADDR_PKT1[7:4]) && (addr[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en           <= CTRL_RESET[0];
      port_en      <= CTRL_RESET[7:4];
      last_dest    <= 2'b00;
      last_dropped <= 1'b0;
    end else begin
      if (wr && addr == ADDR_CTRL) begin
        en      <= apb.pwdata[0];
        port_en <= apb.pwdata[7:4];
      end
      if (status_upd) begin
        last_dest    <= dest;
        last_dropped <= status_dropped;
      end
    end
  end

  // A clear and an increment landing together leave the counter at 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
      for (int i = 0; i < 4; i++) pkt_cnt[i] <= '0;
    end else begin
      drop_cnt <= ((wr && addr == ADDR_DROP) ? '0 : drop_cnt) + {{(CNT_W-1){1'b0}}, drop_inc};
      for (int i = 0; i < 4; i++) begin
        pkt_cnt[i] <= ((wr && pkt_sel && addr[3:2] == 2'(i)) ? '0 : pkt_cnt[i])
                      + {{(CNT_W-1){1'b0}}, (pkt_inc && dest == 2'(i))};
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_CTRL:   rdata = {24'b0, port_en, 3'b0, en};
      ADDR_STATUS: rdata = {23'b0, last_dropped, 2'b0, last_dest, 3'b0, busy};
      ADDR_DROP:   rdata = 32'(drop_cnt);
      ADDR_PKT1:   rdata = 32'(pkt_cnt[0]);
      ADDR_PKT2:   rdata = 32'(pkt_cnt[1]);
      ADDR_PKT3:   rdata = 32'(pkt_cnt[2]);
      ADDR_PKT4:   rdata = 32'(pkt_cnt[3]);
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    apb.prdata <= '0;
    else if (rd) apb.prdata <= rdata;
  end

endmodule

// File: rtl/router_apb_ctrl.sv
// rtl/router_apb_ctrl.sv - 1-to-4 serial packet steering FSM with APB-visible control
module router_apb_ctrl
  import router_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  router_apb_if.slave apb,
  input  logic        data_in,
  input  logic        valid_in,
  output logic        out_port1,
  output logic        out_port2,
  output logic        out_port3,
  output logic        out_port4,
  output logic        valid_out
);

  state_t     state_q, state_d;
  logic [1:0] dest_q;
  logic       armed_q;
  logic       en;
  logic [3:0] port_en;
  logic       pkt_inc, drop_inc, status_upd, status_dropped, fwd_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // armed_q waits for valid_in low so a packet cut by reset is not re-parsed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dest_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      armed_q <= armed_q | ~valid_in;
      if (state_q == IDLE && valid_in && armed_q) dest_q[1] <= data_in;
      if (state_q == HDR && valid_in)             dest_q[0] <= data_in;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (valid_in && armed_q) state_d = HDR;
      HDR: begin
        if (!valid_in)                               state_d = IDLE;
        else if (en && port_en[{dest_q[1], data_in}]) state_d = FWD;
        else                                         state_d = DROP;
      end
      FWD:  if (!valid_in) state_d = IDLE;
      DROP: if (!valid_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pkt_inc        = (state_q == FWD) && !valid_in;
    drop_inc       = (state_q == HDR || state_q == DROP) && !valid_in;
    status_upd     = (state_q == FWD || state_q == DROP) && !valid_in;
    status_dropped = (state_q == DROP);
    fwd_bit        = (state_q == FWD) && valid_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out <= 1'b0;
      out_port1 <= 1'b0;
      out_port2 <= 1'b0;
      out_port3 <= 1'b0;
      out_port4 <= 1'b0;
    end else begin
      valid_out <= fwd_bit;
      out_port1 <= fwd_bit && dest_q == 2'd0 && data_in;
      out_port2 <= fwd_bit && dest_q == 2'd1 && data_in;
      out_port3 <= fwd_bit && dest_q == 2'd2 && data_in;
      out_port4 <= fwd_bit && dest_q == 2'd3 && data_in;
    end
  end

  router_apb_regs #(.CNT_W(CNT_W)) u_regs (
    .clk            (clk),
    .rst            (rst),
    .apb            (apb),
    .busy           (state_q != IDLE),
    .pkt_inc        (pkt_inc),
    .drop_inc       (drop_inc),
    .status_upd     (status_upd),
    .status_dropped (status_dropped),
    .dest           (dest_q),
    .en             (en),
    .port_en        (port_en)
  );

endmodule

// File: tb/tb_router_apb_ctrl.sv
// tb/tb_router_apb_ctrl.sv - directed self-checking bench for router_apb_ctrl
module tb_router_apb_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic data_in, valid_in;
  logic out_port1, out_port2, out_port3, out_port4, valid_out;
  logic [3:0]  outs;
  logic [31:0] rd;
  int pass_cnt = 0;
  int total = 0;

  router_apb_if apb ();

  router_apb_ctrl #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .apb       (apb),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .out_port1 (out_port1),
    .out_port2 (out_port2),
    .out_port3 (out_port3),
    .out_port4 (out_port4),
    .valid_out (valid_out)
  );

  assign outs = {out_port4, out_port3, out_port2, out_port1};

  always #5 clk = ~clk;

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = addr; apb.pwdata = data;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = addr;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    data = apb.prdata;
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  // Drives bits[n-1:0] MSB first; exp_port < 0 means the payload must not appear.
  task automatic send_pkt(input logic [15:0] bits, input int n, input int exp_port);
    logic [3:0] exp_outs;
    logic       exp_v;
    for (int i = n - 1; i >= 0; i--) begin
      valid_in = 1'b1;
      data_in  = bits[i];
      @(posedge clk); #1;
      exp_v    = (exp_port >= 0) && (i <= n - 3);
      exp_outs = exp_v ? (4'(bits[i]) << exp_port) : 4'b0000;
      total++;
      if ({valid_out, outs} !== {exp_v, exp_outs})
        $display("FAIL pkt_bit%0d got valid=%b ports=%b exp valid=%b ports=%b", i, valid_out, outs, exp_v, exp_outs);
      else pass_cnt++;
    end
    valid_in = 1'b0;
    data_in  = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({valid_out, outs} !== 5'b0)
      $display("FAIL pkt_tail got valid=%b ports=%b exp 0", valid_out, outs);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    rst = 1'b0; data_in = 1'b0; valid_in = 1'b0;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({valid_out, outs, apb.prdata} !== 37'b0) $display("FAIL reset_outputs got %b/%b/%h exp 0", valid_out, outs, apb.prdata);
    else pass_cnt++;
    rst = 1'b1;
    apb_read(32'h00, rd); total++;
    if (rd !== 32'hF0) $display("FAIL reset_ctrl got %h exp %h", rd, 32'hF0); else pass_cnt++;
    apb_read(32'h04, rd); total++;
    if (rd !== 32'h0) $display("FAIL reset_status got %h exp 0", rd); else pass_cnt++;
    apb_read(32'h08, rd); total++;
    if (rd !== 32'h0) $display("FAIL reset_drop got %h exp 0", rd); else pass_cnt++;
    apb_read(32'h10, rd); total++;
    if (rd !== 32'h0) $display("FAIL reset_pkt1 got %h exp 0", rd); else pass_cnt++;
    apb_read(32'h40, rd); total++;
    if (rd !== 32'h0) $display("FAIL unmapped got %h exp 0", rd); else pass_cnt++;
  endtask

  task automatic test_forward;
    apb_write(32'h00, 32'hF1);
    send_pkt(16'b101011, 6, 2);
    apb_read(32'h18, rd); total++;
    if (rd !== 32'h1) $display("FAIL fwd_pkt3 got %h exp 1", rd); else pass_cnt++;
    apb_read(32'h04, rd); total++;
    if (rd !== 32'h20) $display("FAIL fwd_status got %h exp %h", rd, 32'h20); else pass_cnt++;
  endtask

  task automatic test_drop;
    apb_write(32'h00, 32'h71);
    send_pkt(16'b1110110, 7, -1);
    apb_read(32'h08, rd); total++;
    if (rd !== 32'h1) $display("FAIL drop_cnt got %h exp 1", rd); else pass_cnt++;
    apb_read(32'h04, rd); total++;
    if (rd !== 32'h130) $display("FAIL drop_status got %h exp %h", rd, 32'h130); else pass_cnt++;
  endtask

  task automatic test_runt;
    send_pkt(16'b1, 1, -1);
    apb_read(32'h08, rd); total++;
    if (rd !== 32'h2) $display("FAIL runt_drop got %h exp 2", rd); else pass_cnt++;
    apb_read(32'h18, rd); total++;
    if (rd !== 32'h1) $display("FAIL runt_pkt3 got %h exp 1", rd); else pass_cnt++;
    apb_read(32'h04, rd); total++;
    if (rd !== 32'h130) $display("FAIL runt_status got %h exp %h", rd, 32'h130); else pass_cnt++;
  endtask

  task automatic test_ctrl_mid_packet;
    apb_write(32'h00, 32'hF1);
    fork
      send_pkt(16'b0010110011, 10, 0);
      begin
        repeat (3) @(posedge clk);
        apb_write(32'h00, 32'h0);
      end
    join
    apb_read(32'h10, rd); total++;
    if (rd !== 32'h1) $display("FAIL mid_pkt1 got %h exp 1", rd); else pass_cnt++;
    apb_read(32'h00, rd); total++;
    if (rd !== 32'h0) $display("FAIL mid_ctrl got %h exp 0", rd); else pass_cnt++;
    send_pkt(16'b0011, 4, -1);
    apb_read(32'h08, rd); total++;
    if (rd !== 32'h3) $display("FAIL mid_drop got %h exp 3", rd); else pass_cnt++;
    apb_read(32'h04, rd); total++;
    if (rd !== 32'h100) $display("FAIL mid_status got %h exp %h", rd, 32'h100); else pass_cnt++;
  endtask

  task automatic test_clear_collision;
    apb_write(32'h08, 32'h0);
    apb_read(32'h08, rd); total++;
    if (rd !== 32'h0) $display("FAIL clr_drop got %h exp 0", rd); else pass_cnt++;
    apb_write(32'h00, 32'hF1);
    send_pkt(16'b0110, 4, 1);
    fork
      send_pkt(16'b0110, 4, 1);
      begin
        repeat (2) @(posedge clk);
        apb_write(32'h14, 32'h0);
      end
    join
    apb_read(32'h14, rd); total++;
    if (rd !== 32'h1) $display("FAIL collide_pkt2 got %h exp 1", rd); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    valid_in = 1'b1; data_in = 1'b0;
    @(posedge clk); #1;
    data_in = 1'b1;
    @(posedge clk); #1;
    data_in = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({valid_out, outs} !== 5'b10010) $display("FAIL pre_rst got valid=%b ports=%b exp 1/0010", valid_out, outs);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total++;
    if ({valid_out, outs} !== 5'b0) $display("FAIL rst_async got valid=%b ports=%b exp 0", valid_out, outs);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b1;
    apb_read(32'h04, rd); total++;
    if (rd !== 32'h0) $display("FAIL resync_busy got %h exp 0", rd); else pass_cnt++;
    valid_in = 1'b0; data_in = 1'b0;
    @(posedge clk); #1;
    apb_read(32'h14, rd); total++;
    if (rd !== 32'h0) $display("FAIL rst_pkt2 got %h exp 0", rd); else pass_cnt++;
    apb_read(32'h00, rd); total++;
    if (rd !== 32'hF0) $display("FAIL rst_ctrl got %h exp %h", rd, 32'hF0); else pass_cnt++;
    apb_write(32'h00, 32'hF1);
    send_pkt(16'b1110, 4, 3);
    apb_read(32'h1C, rd); total++;
    if (rd !== 32'h1) $display("FAIL post_rst_pkt4 got %h exp 1", rd); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_drop();
    test_runt();
    test_ctrl_mid_packet();
    test_clear_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
